// File: rtl/sva_range_monitor.sv
// Checker for NUM_CH properties "ante |-> ##[MIN_DLY:MAX_DLY] cons" with per-channel disable,
// overlapping attempts, registered pass/fail pulses, saturating counters and a sticky fail flag.
module sva_range_monitor #(
    parameter int NUM_CH  = 4,
    parameter int MIN_DLY = 1,
    parameter int MAX_DLY = 3,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       dis,
    input  logic                    clr,
    input  logic [NUM_CH-1:0]       ante,
    input  logic [NUM_CH-1:0]       cons,
    output logic [NUM_CH-1:0]       pass_o,
    output logic [NUM_CH-1:0]       fail_o,
    output logic [NUM_CH*CNT_W-1:0] pass_cnt,
    output logic [NUM_CH*CNT_W-1:0] fail_cnt,
    output logic                    fail_any
);

    // Wide enough to hold the number of hits a single cycle can produce (up to MAX_DLY+1).
    localparam int PC_W  = $clog2(MAX_DLY + 2);
    localparam int SUM_W = CNT_W + PC_W;

    // pend_q[ch][k] marks an outstanding attempt that started k cycles ago.
    logic [MAX_DLY:1]   pend_q     [NUM_CH];
    logic [MAX_DLY:1]   pend_d     [NUM_CH];
    logic [MAX_DLY:0]   age        [NUM_CH];
    logic [MAX_DLY:0]   hit        [NUM_CH];
    logic [PC_W-1:0]    hit_cnt    [NUM_CH];
    logic [CNT_W-1:0]   pass_cnt_q [NUM_CH];
    logic [CNT_W-1:0]   fail_cnt_q [NUM_CH];
    logic [NUM_CH-1:0]  expire;
    logic [NUM_CH-1:0]  any_hit;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] base,
                                                 input logic [PC_W-1:0]  inc);
        logic [SUM_W-1:0] sum;
        sum = {{PC_W{1'b0}}, base} + {{CNT_W{1'b0}}, inc};
        if (|sum[SUM_W-1:CNT_W]) begin
            return {CNT_W{1'b1}};
        end
        return sum[CNT_W-1:0];
    endfunction

    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            age[ch]     = {pend_q[ch], ante[ch]};
            hit[ch]     = '0;
            pend_d[ch]  = '0;
            hit_cnt[ch] = '0;
            for (int k = 0; k <= MAX_DLY; k++) begin
                if (k >= MIN_DLY) begin
                    hit[ch][k] = age[ch][k] & cons[ch];
                end
            end
            for (int k = 0; k < MAX_DLY; k++) begin
                pend_d[ch][k+1] = age[ch][k] & ~hit[ch][k];
            end
            expire[ch]  = age[ch][MAX_DLY] & ~hit[ch][MAX_DLY];
            for (int k = 0; k <= MAX_DLY; k++) begin
                hit_cnt[ch] = hit_cnt[ch] + PC_W'(hit[ch][k]);
            end
            any_hit[ch] = |hit[ch];
            // A disabled channel forgets everything and evaluates nothing this cycle.
            if (dis[ch]) begin
                hit[ch]     = '0;
                pend_d[ch]  = '0;
                hit_cnt[ch] = '0;
                expire[ch]  = 1'b0;
                any_hit[ch] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                pend_q[ch]     <= '0;
                pass_cnt_q[ch] <= '0;
                fail_cnt_q[ch] <= '0;
            end
            pass_o   <= '0;
            fail_o   <= '0;
            fail_any <= 1'b0;
        end else begin
            pass_o <= any_hit;
            fail_o <= expire;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                pend_q[ch] <= pend_d[ch];
                // Disable outranks clear, so a disabled channel keeps its counts.
                if (!dis[ch]) begin
                    if (clr) begin
                        pass_cnt_q[ch] <= '0;
                        fail_cnt_q[ch] <= '0;
                    end else begin
                        pass_cnt_q[ch] <= sat_add(pass_cnt_q[ch], hit_cnt[ch]);
                        fail_cnt_q[ch] <= sat_add(fail_cnt_q[ch], PC_W'(expire[ch]));
                    end
                end
            end
            if (clr) begin
                fail_any <= 1'b0;
            end else if (|expire) begin
                fail_any <= 1'b1;
            end
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_pack
        assign pass_cnt[ch*CNT_W +: CNT_W] = pass_cnt_q[ch];
        assign fail_cnt[ch*CNT_W +: CNT_W] = fail_cnt_q[ch];
    end

endmodule

// File: tb/tb_sva_range_monitor.sv
// Directed bench for sva_range_monitor with a 1..3 cycle window and 4-bit counters.
module tb_sva_range_monitor;

    localparam int NUM_CH  = 4;
    localparam int MIN_DLY = 1;
    localparam int MAX_DLY = 3;
    localparam int CNT_W   = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    clr;
    logic [NUM_CH-1:0]       dis;
    logic [NUM_CH-1:0]       ante;
    logic [NUM_CH-1:0]       cons;
    logic [NUM_CH-1:0]       pass_o;
    logic [NUM_CH-1:0]       fail_o;
    logic [NUM_CH*CNT_W-1:0] pass_cnt;
    logic [NUM_CH*CNT_W-1:0] fail_cnt;
    logic                    fail_any;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    always #5 clk = ~clk;

    sva_range_monitor #(
        .NUM_CH (NUM_CH),
        .MIN_DLY(MIN_DLY),
        .MAX_DLY(MAX_DLY),
        .CNT_W  (CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .dis     (dis),
        .clr     (clr),
        .ante    (ante),
        .cons    (cons),
        .pass_o  (pass_o),
        .fail_o  (fail_o),
        .pass_cnt(pass_cnt),
        .fail_cnt(fail_cnt),
        .fail_any(fail_any)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Hold one set of inputs for a cycle; afterwards outputs show that cycle's evaluation.
    task automatic cyc(input logic [3:0] a, input logic [3:0] c, input logic [3:0] d);
        ante = a;
        cons = c;
        dis  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(4'b0000, 4'b0000, 4'b0000);
    endtask

    function automatic logic [CNT_W-1:0] pcnt(input int ch);
        return pass_cnt[ch*CNT_W +: CNT_W];
    endfunction

    function automatic logic [CNT_W-1:0] fcnt(input int ch);
        return fail_cnt[ch*CNT_W +: CNT_W];
    endfunction

    // ch1 burst: n cycles of ante, then one cons cycle satisfying all n attempts.
    task automatic pass_burst(input int n);
        for (int i = 0; i < n; i++) cyc(4'b0010, 4'b0000, 4'b0000);
        cyc(4'b0000, 4'b0010, 4'b0000);
    endtask

    initial begin
        rst = 1'b1;
        clr = 1'b0;
        idle();
        idle();
        check("rst_pass_o", pass_o, 0);
        check("rst_fail_o", fail_o, 0);
        check("rst_pass_cnt", pass_cnt, 0);
        check("rst_fail_cnt", fail_cnt, 0);
        check("rst_fail_any", fail_any, 0);
        rst = 1'b0;

        // Single attempt satisfied at age 2.
        cyc(4'b0001, 4'b0000, 4'b0000);
        check("t1_pass_early", pass_o, 0);
        idle();
        cyc(4'b0000, 4'b0001, 4'b0000);
        check("t1_pass", pass_o, 4'b0001);
        for (int i = 0; i < 3; i++) begin
            idle();
            check("t1_no_fail", fail_o, 0);
        end
        check("t1_pass_cnt", pcnt(0), 1);
        check("t1_fail_any", fail_any, 0);

        // Unsatisfied attempt expires after MAX_DLY.
        cyc(4'b0001, 4'b0000, 4'b0000);
        idle();
        check("t2_fail_early1", fail_o, 0);
        idle();
        check("t2_fail_early2", fail_o, 0);
        idle();
        check("t2_fail", fail_o, 4'b0001);
        check("t2_fail_cnt", fcnt(0), 1);
        check("t2_fail_any", fail_any, 1);
        idle();
        check("t2_fail_pulse", fail_o, 0);
        check("t2_fail_any_sticky", fail_any, 1);

        // Two overlapping attempts satisfied by one cons.
        cyc(4'b0010, 4'b0000, 4'b0000);
        cyc(4'b0010, 4'b0000, 4'b0000);
        cyc(4'b0000, 4'b0010, 4'b0000);
        check("t3_pass", pass_o, 4'b0010);
        idle();
        check("t3_pass_pulse", pass_o, 0);
        check("t3_pass_cnt", pcnt(1), 2);
        for (int i = 0; i < 3; i++) begin
            idle();
            check("t3_no_fail", fail_o, 0);
        end

        // Same-cycle cons is below MIN_DLY and does not count.
        cyc(4'b0100, 4'b0100, 4'b0000);
        check("t4_no_pass", pass_o, 0);
        idle();
        idle();
        idle();
        check("t4_fail", fail_o, 4'b0100);
        check("t4_fail_cnt", fcnt(2), 1);
        check("t4_pass_cnt", pcnt(2), 0);

        // Disable drops the pending attempt.
        cyc(4'b1000, 4'b0000, 4'b0000);
        cyc(4'b0000, 4'b0000, 4'b1000);
        cyc(4'b0000, 4'b1000, 4'b0000);
        check("t5_dis_no_pass", pass_o, 0);
        for (int i = 0; i < 3; i++) begin
            idle();
            check("t5_dis_pass", pass_o, 0);
            check("t5_dis_fail", fail_o, 0);
        end
        check("t5_dis_pcnt", pcnt(3), 0);
        check("t5_dis_fcnt", fcnt(3), 0);

        // Reset mid-attempt clears everything and reports nothing.
        cyc(4'b1000, 4'b0000, 4'b0000);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        check("t5_rst_pass_o", pass_o, 0);
        check("t5_rst_fail_o", fail_o, 0);
        check("t5_rst_pass_cnt", pass_cnt, 0);
        check("t5_rst_fail_cnt", fail_cnt, 0);
        check("t5_rst_fail_any", fail_any, 0);
        cyc(4'b0000, 4'b1000, 4'b0000);
        check("t5_rst_no_pass", pass_o, 0);
        for (int i = 0; i < 3; i++) begin
            idle();
            check("t5_rst_no_fail", fail_o, 0);
        end

        // Continuous ante: fail counter saturates, then clr wins over a same-cycle fail.
        for (int i = 0; i < 20; i++) begin
            cyc(4'b0001, 4'b0000, 4'b0000);
            if (i == 15) check("t6_fcnt_13", fcnt(0), 13);
        end
        check("t6_fcnt_sat", fcnt(0), 15);
        check("t6_fail_any", fail_any, 1);
        clr = 1'b1;
        idle();
        clr = 1'b0;
        check("t6_clr_fcnt", fcnt(0), 0);
        check("t6_clr_fail_any", fail_any, 0);
        check("t6_clr_fail_pulse", fail_o, 4'b0001);
        idle();
        check("t6_after_clr_fcnt1", fcnt(0), 1);
        check("t6_after_clr_any", fail_any, 1);
        idle();
        check("t6_after_clr_fcnt2", fcnt(0), 2);
        idle();
        check("t6_drained", fail_o, 0);
        check("t6_fcnt_hold", fcnt(0), 2);

        // Multi-hit increments and overshoot saturation on the pass counter.
        for (int b = 0; b < 4; b++) pass_burst(3);
        check("t7_pcnt_12", pcnt(1), 12);
        pass_burst(2);
        check("t7_pass", pass_o, 4'b0010);
        check("t7_pcnt_14", pcnt(1), 14);
        pass_burst(3);
        check("t7_pcnt_sat", pcnt(1), 15);
        check("t7_no_fail", fcnt(1), 0);

        // Disable outranks clr: the disabled channel keeps its count.
        clr = 1'b1;
        cyc(4'b0000, 4'b0000, 4'b0010);
        clr = 1'b0;
        check("t8_dis_hold", pcnt(1), 15);
        check("t8_clr_other", fcnt(0), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
